fifo_uart_drain: RTL and testbench

- Downstream consumer of the 4-bit, 8-deep FIFO on the read side.
- Pops one word at a time and serializes it onto a single UART-style line: start bit, data bits LSB-first, optional parity bit, stop bit.
- Lets the FIFO contents leave the chip on one output pin.
- Also exports busy status and a running count of frames sent.

---
 rtl/fifo_uart_drain.sv | 134 +++++++++++++
 tb/tb_fifo_uart_drain.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_drain.sv
// Read-side drain for a first-word-fall-through FIFO: pops one word at a time and
// sends it as a UART frame (start, LSB-first data, optional parity, stop) on tx.
`timescale 1ns/1ps
module fifo_uart_drain #(
   parameter int WIDTH        = 4,
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_EN    = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             parity_odd,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_rdata,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy,
   output logic [7:0]       frame_cnt,
   output logic [2:0]       state_dbg
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t           state, state_d;
   logic [BW-1:0]    baud_cnt, baud_d;
   logic [IW-1:0]    bit_idx, bit_idx_d;
   logic [WIDTH-1:0] shift_reg, shift_d;
   logic             parity_bit, parity_d;
   logic [7:0]       cnt_d;
   logic             tx_d;
   logic             pop;
   logic             baud_last;

   // Handshake: fifo_rd_en is a one-cycle pop strobe; the FIFO head is valid whenever
   // fifo_empty=0, and the word is consumed on the clock edge that ends the strobe cycle.
   assign baud_last  = (baud_cnt == BAUD_LAST);
   assign fifo_rd_en = pop & rst_n;
   assign busy       = (state != IDLE) | fifo_rd_en;
   assign state_dbg  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         tx         <= 1'b1;
         frame_cnt  <= 8'd0;
      end else begin
         state      <= state_d;
         baud_cnt   <= baud_d;
         bit_idx    <= bit_idx_d;
         shift_reg  <= shift_d;
         parity_bit <= parity_d;
         tx         <= tx_d;
         frame_cnt  <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state;
      baud_d    = baud_cnt;
      bit_idx_d = bit_idx;
      shift_d   = shift_reg;
      parity_d  = parity_bit;
      cnt_d     = frame_cnt;
      pop       = 1'b0;
      tx_d      = 1'b1;

      if (state != IDLE) begin
         baud_d = baud_last ? '0 : baud_cnt + 1'b1;
      end

      case (state)
         IDLE: pop = enable & ~fifo_empty;
         START: begin
            if (baud_last) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (baud_last) begin
               shift_d = shift_reg >> 1;
               if (bit_idx == IDX_LAST) begin
                  state_d = PARITY_EN ? PARITY : STOP;
               end else begin
                  bit_idx_d = bit_idx + 1'b1;
               end
            end
         end
         PARITY: begin
            if (baud_last) state_d = STOP;
         end
         STOP: begin
            if (baud_last) begin
               cnt_d = frame_cnt + 8'd1;
               if (enable && !fifo_empty) pop = 1'b1;
               else state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A pop (from IDLE or the last stop cycle) captures the head word and its parity.
      if (pop) begin
         state_d  = START;
         baud_d   = '0;
         shift_d  = fifo_rdata;
         parity_d = (^fifo_rdata) ^ parity_odd;
      end

      // tx is registered, so it is driven from the state being entered.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = parity_d;
         default: tx_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Bench for fifo_uart_drain: queue-backed FIFO model, frame monitor with an expected
// queue, a second no-parity instance, and directed reset/enable/wrap scenarios.
`timescale 1ns/1ps
module tb_fifo_uart_drain;

   localparam int W       = 4;
   localparam int CPB     = 4;
   localparam int NCYC    = (2 + W + 1) * CPB;
   localparam int NCYC_NP = (2 + W) * CPB;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         enable = 1'b0;
   logic         parity_odd = 1'b0;
   logic         fifo_empty = 1'b1;
   logic [W-1:0] fifo_rdata = '0;
   logic         fifo_rd_en, tx, busy;
   logic [7:0]   frame_cnt;
   logic [2:0]   state_dbg;

   logic         np_enable = 1'b1;
   logic         np_parity_odd = 1'b0;
   logic         np_empty = 1'b1;
   logic [W-1:0] np_rdata = '0;
   logic         np_rd_en, np_tx, np_busy;
   logic [7:0]   np_frame_cnt;
   logic [2:0]   np_state;

   logic [W-1:0] fifo_q[$];
   logic [W:0]   exp_q[$];
   int n_cmp = 0, n_err = 0;
   int pop_cnt = 0, bad_pop = 0, np_pops = 0, frames_done = 0, busy_bad = 0;

   fifo_uart_drain #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .parity_odd(parity_odd),
      .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en),
      .tx(tx), .busy(busy), .frame_cnt(frame_cnt), .state_dbg(state_dbg)
   );

   fifo_uart_drain #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut_np (
      .clk(clk), .rst_n(rst_n), .enable(np_enable), .parity_odd(np_parity_odd),
      .fifo_empty(np_empty), .fifo_rdata(np_rdata), .fifo_rd_en(np_rd_en),
      .tx(np_tx), .busy(np_busy), .frame_cnt(np_frame_cnt), .state_dbg(np_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected tx samples of one frame, one bit per clock cycle.
   function automatic logic [31:0] frame_vec(input logic [W-1:0] d, input logic odd, input bit par_en);
      logic [31:0] v;
      logic [7:0]  seq;
      int          nb;
      v = '0;
      seq = '0;
      for (int i = 0; i < W; i++) seq[1 + i] = d[i];
      nb = 1 + W;
      if (par_en) begin
         seq[nb] = (^d) ^ odd;
         nb++;
      end
      seq[nb] = 1'b1;
      nb++;
      for (int s = 0; s < nb * CPB; s++) v[s] = seq[s / CPB];
      return v;
   endfunction

   // driver
   task automatic push_word(input logic [W-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back({parity_odd, w});
      fifo_empty <= 1'b0;
      fifo_rdata <= fifo_q[0];
   endtask

   task automatic wait_frames(input int target, input int budget);
      int t;
      t = 0;
      while (frames_done < target && t < budget) begin
         @(posedge clk);
         t++;
      end
      check("frames_done", frames_done, target);
   endtask

   // FIFO models
   initial forever begin
      @(posedge clk);
      if (fifo_rd_en) begin
         pop_cnt++;
         if (fifo_q.size() == 0) bad_pop++;
         else void'(fifo_q.pop_front());
         fifo_empty <= (fifo_q.size() == 0);
         if (fifo_q.size() > 0) fifo_rdata <= fifo_q[0];
      end
   end

   initial forever begin
      @(posedge clk);
      if (np_rd_en) begin
         np_pops++;
         np_empty <= 1'b1;
      end
   end

   // scoreboard: collect each frame's tx samples and compare against the expected queue
   logic [31:0] mon_vec = '0;
   int          mon_idx = 0;
   bit          mon_active = 1'b0;
   logic [W:0]  mon_exp;
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         mon_active = 1'b0;
         mon_idx = 0;
      end else begin
         if (!mon_active && tx == 1'b0) begin
            mon_active = 1'b1;
            mon_idx = 0;
            mon_vec = '0;
         end
         if (mon_active) begin
            mon_vec[mon_idx] = tx;
            if (!busy) busy_bad++;
            if (fifo_rd_en) check("pop_in_last_stop", mon_idx, NCYC - 1);
            if (mon_idx == NCYC - 1) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", 1, 0);
               end else begin
                  mon_exp = exp_q.pop_front();
                  check("frame", mon_vec, frame_vec(mon_exp[W-1:0], mon_exp[W], 1'b1));
               end
               frames_done++;
               mon_active = 1'b0;
            end else begin
               mon_idx++;
            end
         end
      end
   end

   initial begin
      #400000;
      n_err++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      int p0, f0, bad, t, busy_low, low_cnt;
      logic [31:0] np_vec;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // reset / idle
      #2 rst_n = 1'b0;
      #1;
      check("rst_tx", tx, 1);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_state", state_dbg, 0);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0 || frame_cnt !== 8'd0) bad++;
      end
      check("idle_bad_cycles", bad, 0);

      // single frame, even parity
      parity_odd = 1'b0;
      p0 = pop_cnt;
      push_word(4'hA);
      wait_frames(1, 200);
      @(negedge clk);
      check("t2_busy_after", busy, 0);
      check("t2_tx_after", tx, 1);
      check("t2_pops", pop_cnt - p0, 1);
      check("t2_frame_cnt", frame_cnt, 1);

      // odd parity
      parity_odd = 1'b1;
      push_word(4'hA);
      wait_frames(2, 200);
      @(negedge clk);
      check("t3_frame_cnt", frame_cnt, 2);

      // no-parity instance: 24-cycle frame
      np_rdata <= 4'hA;
      np_empty <= 1'b0;
      np_vec = '0;
      for (int s = 0; s < NCYC_NP; s++) begin
         @(negedge clk);
         np_vec[s] = np_tx;
      end
      @(negedge clk);
      check("np_frame", np_vec, frame_vec(4'hA, 1'b0, 1'b0));
      check("np_tx_after", np_tx, 1);
      check("np_busy_after", np_busy, 0);
      check("np_pops", np_pops, 1);
      check("np_frame_cnt", np_frame_cnt, 1);

      // back-to-back frames
      enable = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) push_word(W'(i));
      p0 = pop_cnt;
      f0 = frames_done;
      @(negedge clk);
      enable = 1'b1;
      busy_low = 0;
      t = 0;
      while (frames_done < f0 + 8 && t < 700) begin
         @(posedge clk);
         #2;
         t++;
         if (frames_done < f0 + 8 && !busy) busy_low++;
      end
      check("t4_frames", frames_done, f0 + 8);
      check("t4_cycles", t, 8 * NCYC + 1);
      check("t4_busy_low", busy_low, 0);
      @(negedge clk);
      check("t4_pops", pop_cnt - p0, 8);
      check("t4_frame_cnt", frame_cnt, 10);

      // enable dropped mid-data
      enable = 1'b0;
      @(negedge clk);
      push_word(4'h5);
      push_word(4'h9);
      push_word(4'hC);
      p0 = pop_cnt;
      f0 = frames_done;
      enable = 1'b1;
      repeat (10) @(negedge clk);
      enable = 1'b0;
      wait_frames(f0 + 1, 100);
      low_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) low_cnt++;
      end
      check("t5_tx_low_after", low_cnt, 0);
      check("t5_pops", pop_cnt - p0, 1);
      check("t5_fifo_left", fifo_q.size(), 2);
      check("t5_busy", busy, 0);
      check("t5_frame_cnt", frame_cnt, 11);

      // reset during data bit 2; the popped word is lost
      @(negedge clk);
      enable = 1'b1;
      p0 = pop_cnt;
      repeat (14) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("t6_tx", tx, 1);
      check("t6_busy", busy, 0);
      check("t6_rd_en", fifo_rd_en, 0);
      check("t6_frame_cnt", frame_cnt, 0);
      check("t6_pops", pop_cnt - p0, 1);
      void'(exp_q.pop_front());
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      f0 = frames_done;
      wait_frames(f0 + 1, 100);
      @(negedge clk);
      check("t6_frame_cnt_after", frame_cnt, 1);
      check("t6_pops_after", pop_cnt - p0, 2);

      // frame counter wrap
      parity_odd = 1'($urandom_range(0, 1));
      f0 = frames_done;
      for (int i = 0; i < 254; i++) push_word(W'($urandom_range(0, 15)));
      wait_frames(f0 + 254, 254 * NCYC + 100);
      @(negedge clk);
      check("wrap_255", frame_cnt, 255);
      push_word(W'($urandom_range(0, 15)));
      wait_frames(f0 + 255, 200);
      @(negedge clk);
      check("wrap_0", frame_cnt, 0);

      check("exp_q_left", exp_q.size(), 0);
      check("bad_pops", bad_pop, 0);
      check("busy_in_frame", busy_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
